// File: rtl/shift_seq_pkg.sv
// shift_seq_pkg: shared state encoding and sizing for the shift sequencer
package shift_seq_pkg;
  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;
  localparam int WIDTH = 4;
  localparam int SHIFT_CYCLES = 9;
  localparam int CAP_START = 5;
  localparam logic [3:0] CNT_LAST = 4'(SHIFT_CYCLES - 1);
  localparam logic [3:0] CAP_FIRST = 4'(CAP_START);
endpackage

// File: rtl/shift_seq_if.sv
// shift_seq_if: word-in / word-out handshake bundle of the shift sequencer
// err only exists when SHIFT_SEQ_CHK_EN is defined
interface shift_seq_if;
  import shift_seq_pkg::*;
  logic [WIDTH-1:0] din;
  logic dir;
  logic din_valid;
  logic din_ready;
  logic [WIDTH-1:0] dout;
  logic dout_valid;
  logic dout_ready;
  logic busy;
`ifdef SHIFT_SEQ_CHK_EN
  logic err;
  modport master (output din, dir, din_valid, dout_ready, input din_ready, dout, dout_valid, busy, err);
  modport slave (input din, dir, din_valid, dout_ready, output din_ready, dout, dout_valid, busy, err);
`else
  modport master (output din, dir, din_valid, dout_ready, input din_ready, dout, dout_valid, busy);
  modport slave (input din, dir, din_valid, dout_ready, output din_ready, dout, dout_valid, busy);
`endif
endinterface

// File: rtl/sr4_bidir.sv
// sr4_bidir: 4-bit bidirectional serial shift register with registered serial output
module sr4_bidir (
  input  logic clk,
  input  logic rst,
  input  logic s_in,
  input  logic mode,
  output logic s_out
);
  logic [3:0] temp;
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      temp  <= '0;
      s_out <= 1'b0;
    end else begin
      temp  <= mode ? {temp[2:0], s_in} : {s_in, temp[3:1]};
      s_out <= mode ? temp[3] : temp[0];
    end
endmodule

// File: rtl/shift_seq_ctrl.sv
// shift_seq_ctrl: sends a word through sr4_bidir and reassembles it from the serial output
// Optional loopback checker (err) enabled by defining SHIFT_SEQ_CHK_EN
module shift_seq_ctrl
  import shift_seq_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  shift_seq_if.slave  bus
);
  state_t state, state_nx;
  logic [3:0] cnt;
  logic [WIDTH-1:0] din_q, cap, cap_nx;
  logic dir_q, valid, accept, capture, s_in, s_out;
  logic [1:0] cap_idx;
  sr4_bidir u_sr (.clk(clk), .rst(rst), .s_in(s_in), .mode(dir_q), .s_out(s_out));
  always_ff @(posedge clk or negedge rst)
    if (!rst) state <= IDLE;
    else state <= state_nx;
  always_comb begin
    state_nx = state == IDLE  ? (bus.din_valid ? SHIFT : IDLE) :
               state == SHIFT ? (cnt == CNT_LAST ? DONE : SHIFT) :
                                (bus.dout_ready ? IDLE : DONE);
    accept   = state == IDLE && bus.din_valid;
    s_in     = state == SHIFT && cnt < 4'd4 && (dir_q ? din_q[~cnt[1:0]] : din_q[cnt[1:0]]);
    capture  = state == SHIFT && cnt >= CAP_FIRST;
    // Serial output lags the input by WIDTH+1 cycles, so capture walks the word in send order
    cap_idx  = 2'(dir_q ? CNT_LAST - cnt : cnt - CAP_FIRST);
    cap_nx   = cap;
    if (capture) cap_nx[cap_idx] = s_out;
  end
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      cnt   <= '0;
      din_q <= '0;
      dir_q <= 1'b0;
      cap   <= '0;
      valid <= 1'b0;
    end else begin
      if (accept) begin
        din_q <= bus.din;
        dir_q <= bus.dir;
        cnt   <= '0;
      end else if (state == SHIFT) cnt <= cnt + 4'd1;
      cap   <= cap_nx;
      valid <= state_nx == DONE;
    end
`ifdef SHIFT_SEQ_CHK_EN
  logic err_q;
  always_ff @(posedge clk or negedge rst)
    if (!rst) err_q <= 1'b0;
    else if (accept) err_q <= 1'b0;
    else if (state == SHIFT && state_nx == DONE) err_q <= cap_nx != din_q;
  assign bus.err = err_q;
`endif
  assign bus.din_ready  = state == IDLE;
  assign bus.busy       = state != IDLE;
  assign bus.dout       = cap;
  assign bus.dout_valid = valid;
endmodule

// File: tb/tb_shift_seq_ctrl.sv
// tb_shift_seq_ctrl: directed self-checking bench for shift_seq_ctrl
module tb_shift_seq_ctrl;
  logic clk = 1'b0;
  logic rst = 1'b0;
  int checks = 0;
  int failures = 0;
  shift_seq_if bus ();
  shift_seq_ctrl dut (.clk(clk), .rst(rst), .bus(bus));
  always #5 clk = ~clk;
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic send(input logic [3:0] d, input logic r);
    bus.din = d;
    bus.dir = r;
    bus.din_valid = 1'b1;
    tick();
    bus.din_valid = 1'b0;
  endtask
  task automatic test_reset;
    rst = 1'b0;
    #1;
    checks++; if (bus.dout !== 4'b0000) begin failures++; $display("FAIL reset_dout got=%b exp=0000", bus.dout); end
    checks++; if (bus.dout_valid !== 1'b0) begin failures++; $display("FAIL reset_dout_valid got=%b exp=0", bus.dout_valid); end
    checks++; if (bus.busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", bus.busy); end
`ifdef SHIFT_SEQ_CHK_EN
    checks++; if (bus.err !== 1'b0) begin failures++; $display("FAIL reset_err got=%b exp=0", bus.err); end
`endif
    tick();
    rst = 1'b1;
    tick();
    checks++; if (bus.din_ready !== 1'b1) begin failures++; $display("FAIL reset_din_ready got=%b exp=1", bus.din_ready); end
  endtask
  task automatic test_basic;
    send(4'b1001, 1'b0);
    checks++; if (bus.din_ready !== 1'b0) begin failures++; $display("FAIL basic_ready_drop got=%b exp=0", bus.din_ready); end
    checks++; if (bus.busy !== 1'b1) begin failures++; $display("FAIL basic_busy got=%b exp=1", bus.busy); end
    for (int i = 1; i <= 9; i++) begin
      tick();
      if (i == 8) begin
        checks++; if (bus.dout_valid !== 1'b0) begin failures++; $display("FAIL basic_early_valid got=%b exp=0", bus.dout_valid); end
      end
    end
    checks++; if (bus.dout_valid !== 1'b1) begin failures++; $display("FAIL basic_valid got=%b exp=1", bus.dout_valid); end
    checks++; if (bus.dout !== 4'b1001) begin failures++; $display("FAIL basic_dout got=%b exp=1001", bus.dout); end
    bus.dout_ready = 1'b1;
    tick();
    bus.dout_ready = 1'b0;
    checks++; if (bus.dout_valid !== 1'b0) begin failures++; $display("FAIL basic_valid_clear got=%b exp=0", bus.dout_valid); end
    checks++; if (bus.din_ready !== 1'b1) begin failures++; $display("FAIL basic_idle_ready got=%b exp=1", bus.din_ready); end
  endtask
  task automatic test_dir_toggle;
    send(4'b1100, 1'b1);
    for (int i = 1; i <= 9; i++) begin
      bus.dir = ~bus.dir;
      tick();
      checks++; if (dut.u_sr.mode !== 1'b1) begin failures++; $display("FAIL toggle_mode cyc=%0d got=%b exp=1", i, dut.u_sr.mode); end
    end
    checks++; if (bus.dout_valid !== 1'b1) begin failures++; $display("FAIL toggle_valid got=%b exp=1", bus.dout_valid); end
    checks++; if (bus.dout !== 4'b1100) begin failures++; $display("FAIL toggle_dout got=%b exp=1100", bus.dout); end
    bus.dout_ready = 1'b1;
    tick();
    bus.dout_ready = 1'b0;
  endtask
  task automatic test_hold;
    send(4'b0101, 1'b0);
    repeat (9) tick();
    bus.din = 4'b1111;
    bus.din_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      checks++; if (bus.din_ready !== 1'b0) begin failures++; $display("FAIL hold_ready cyc=%0d got=%b exp=0", i, bus.din_ready); end
      checks++; if (bus.dout_valid !== 1'b1) begin failures++; $display("FAIL hold_valid cyc=%0d got=%b exp=1", i, bus.dout_valid); end
      checks++; if (bus.dout !== 4'b0101) begin failures++; $display("FAIL hold_dout cyc=%0d got=%b exp=0101", i, bus.dout); end
      tick();
      bus.din_valid = 1'b0;
    end
    bus.dout_ready = 1'b1;
    tick();
    bus.dout_ready = 1'b0;
    checks++; if (bus.din_ready !== 1'b1) begin failures++; $display("FAIL hold_release_ready got=%b exp=1", bus.din_ready); end
    checks++; if (bus.dout_valid !== 1'b0) begin failures++; $display("FAIL hold_release_valid got=%b exp=0", bus.dout_valid); end
  endtask
  task automatic test_back_to_back;
    bus.dout_ready = 1'b1;
    send(4'b0001, 1'b0);
    bus.din = 4'b1000;
    bus.din_valid = 1'b1;
    for (int i = 1; i <= 20; i++) begin
      tick();
      if (i == 5) begin
        checks++; if (bus.din_ready !== 1'b0) begin failures++; $display("FAIL b2b_ready_shift got=%b exp=0", bus.din_ready); end
      end
      if (i == 9) begin
        checks++; if (bus.dout_valid !== 1'b1) begin failures++; $display("FAIL b2b_valid1 got=%b exp=1", bus.dout_valid); end
        checks++; if (bus.dout !== 4'b0001) begin failures++; $display("FAIL b2b_dout1 got=%b exp=0001", bus.dout); end
      end
      if (i == 10) begin
        checks++; if (bus.din_ready !== 1'b1) begin failures++; $display("FAIL b2b_ready_idle got=%b exp=1", bus.din_ready); end
      end
      if (i == 11) begin
        checks++; if (bus.din_ready !== 1'b0) begin failures++; $display("FAIL b2b_second_accept got=%b exp=0", bus.din_ready); end
        bus.din_valid = 1'b0;
      end
    end
    checks++; if (bus.dout_valid !== 1'b1) begin failures++; $display("FAIL b2b_valid2 got=%b exp=1", bus.dout_valid); end
    checks++; if (bus.dout !== 4'b1000) begin failures++; $display("FAIL b2b_dout2 got=%b exp=1000", bus.dout); end
    tick();
    bus.dout_ready = 1'b0;
    checks++; if (bus.dout_valid !== 1'b0) begin failures++; $display("FAIL b2b_valid_clear got=%b exp=0", bus.dout_valid); end
  endtask
  task automatic test_reset_mid;
    send(4'b1010, 1'b0);
    repeat (6) tick();
    checks++; if (dut.cnt !== 4'd6) begin failures++; $display("FAIL mid_cnt got=%0d exp=6", dut.cnt); end
    rst = 1'b0;
    #1;
    checks++; if (bus.dout !== 4'b0000) begin failures++; $display("FAIL mid_rst_dout got=%b exp=0000", bus.dout); end
    checks++; if (bus.dout_valid !== 1'b0) begin failures++; $display("FAIL mid_rst_valid got=%b exp=0", bus.dout_valid); end
    checks++; if (bus.busy !== 1'b0) begin failures++; $display("FAIL mid_rst_busy got=%b exp=0", bus.busy); end
    tick();
    tick();
    rst = 1'b1;
    tick();
    checks++; if (bus.din_ready !== 1'b1) begin failures++; $display("FAIL mid_release_ready got=%b exp=1", bus.din_ready); end
    for (int i = 0; i < 12; i++) begin
      tick();
      checks++; if (bus.dout_valid !== 1'b0) begin failures++; $display("FAIL mid_no_valid cyc=%0d got=%b exp=0", i, bus.dout_valid); end
    end
    send(4'b0110, 1'b0);
    repeat (9) tick();
    checks++; if (bus.dout_valid !== 1'b1) begin failures++; $display("FAIL mid_next_valid got=%b exp=1", bus.dout_valid); end
    checks++; if (bus.dout !== 4'b0110) begin failures++; $display("FAIL mid_next_dout got=%b exp=0110", bus.dout); end
    bus.dout_ready = 1'b1;
    tick();
    bus.dout_ready = 1'b0;
  endtask
`ifdef SHIFT_SEQ_CHK_EN
  task automatic test_err;
    send(4'b1111, 1'b0);
    repeat (5) tick();
    force dut.u_sr.s_out = 1'b0;
    repeat (4) tick();
    release dut.u_sr.s_out;
    checks++; if (bus.err !== 1'b1) begin failures++; $display("FAIL err_forced got=%b exp=1", bus.err); end
    bus.dout_ready = 1'b1;
    tick();
    bus.dout_ready = 1'b0;
    send(4'b1010, 1'b1);
    checks++; if (bus.err !== 1'b0) begin failures++; $display("FAIL err_clear_on_accept got=%b exp=0", bus.err); end
    repeat (9) tick();
    checks++; if (bus.err !== 1'b0) begin failures++; $display("FAIL err_normal got=%b exp=0", bus.err); end
    checks++; if (bus.dout !== 4'b1010) begin failures++; $display("FAIL err_normal_dout got=%b exp=1010", bus.dout); end
    bus.dout_ready = 1'b1;
    tick();
    bus.dout_ready = 1'b0;
  endtask
`endif
  initial begin
    bus.din = '0;
    bus.dir = 1'b0;
    bus.din_valid = 1'b0;
    bus.dout_ready = 1'b0;
    test_reset();
    test_basic();
    test_dir_toggle();
    test_hold();
    test_back_to_back();
    test_reset_mid();
`ifdef SHIFT_SEQ_CHK_EN
    test_err();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
  initial begin
    #100000;
    $display("FAIL timeout simulation did not finish");
    $fatal(1, "timeout");
  end
endmodule

// File: doc/shift_seq_ctrl.md
SHIFT_SEQ_CTRL -- requirements
Module: shift_seq_ctrl

Interface
REQ-001 clk  input  1  clock; all state updates on rising edge.
REQ-002 rst  input  1  asynchronous, active-low reset.
REQ-003 din  input  4  parallel word to be sent through the shift register.
REQ-004 dir  input  1  shift direction: 0 = right shift (LSB first), 1 = left shift (MSB first).
REQ-005 din_valid  input  1  din/dir offered.
REQ-006 din_ready  output  1  block idle and able to accept a word.
REQ-007 dout  output  4  reassembled word captured from the register's serial output.
REQ-008 dout_valid  output  1  dout holds a completed word.
REQ-009 dout_ready  input  1  consumer accepts dout.
REQ-010 busy  output  1  high while a transfer is in SHIFT or DONE.
REQ-011 err  output  1  loopback mismatch flag; present only with SHIFT_SEQ_CHK_EN.

Function
REQ-012 The FSM SHALL have states IDLE, SHIFT and DONE.
REQ-013 In IDLE, din_ready SHALL be 1; din_valid=1 SHALL accept the word: latch din and dir, clear the counter cnt (4 bits), and go to SHIFT on the next edge.
REQ-014 The instantiated shift register SHALL be driven with mode = latched dir throughout SHIFT; dir changes after acceptance SHALL have no effect.
REQ-015 SHIFT SHALL last exactly 9 cycles (cnt 0..8), with cnt incrementing by 1 every cycle.
REQ-016 s_in SHALL be: cnt 0..3 -> din bit cnt (dir=0) or din bit 3-cnt (dir=1); cnt 4..8 -> 0.
REQ-017 Register behaviour: right: temp <= {s_in,temp[3:1]}, s_out <= temp[0]; left: temp <= {temp[2:0],s_in}, s_out <= temp[3]; s_out is registered.
REQ-018 During cnt 5..8, s_out SHALL be sampled into capture bit index (cnt-5) for dir=0, or (8-cnt) for dir=1, so that dout equals the latched din.
REQ-019 At the end of cnt=8 the FSM SHALL go to DONE, assert dout_valid and hold dout stable.
REQ-020 In DONE, dout_ready=1 SHALL clear dout_valid and return to IDLE on the next edge; until then, state and dout SHALL be held.
REQ-021 din_ready SHALL be 0 in SHIFT and DONE; din_valid in those states SHALL be ignored.
REQ-022 Minimum accept-to-accept spacing SHALL be 11 cycles (1 IDLE + 9 SHIFT + 1 DONE) with dout_ready held at 1.

Reset
REQ-023 rst=0 SHALL asynchronously force: state IDLE, cnt 0, dout 0, dout_valid 0, busy 0, err 0, and the shift register's temp and s_out to 0.
REQ-024 Reset during SHIFT or DONE SHALL abort the transfer; no dout_valid pulse SHALL follow release.
REQ-025 After rst rises, din_ready SHALL be 1 on the first clock edge.

Configuration
REQ-026 With SHIFT_SEQ_CHK_EN defined: on entry to DONE, err SHALL be set to (dout != latched din) and held until the next acceptance or reset.
REQ-027 Without SHIFT_SEQ_CHK_EN: the err port, the comparator and its register SHALL be absent.

Structure
REQ-028 Shared package shift_seq_pkg SHALL hold the state enum (IDLE/SHIFT/DONE), WIDTH=4, SHIFT_CYCLES=9, and CAP_START=5.
REQ-029 The 4-bit bidirectional serial shift register SHALL be a separate sub-module, sr4_bidir (clk, rst, s_in, mode, s_out), instantiated once.

Verification
REQ-030 Reset, then din=4'b1001, dir=0, one-cycle valid -> din_ready drops next cycle; dout_valid=1 exactly 10 cycles after acceptance, with dout=4'b1001.
REQ-031 din=4'b1100, dir=1, with dir toggled every cycle during SHIFT -> dout=4'b1100; sr4_bidir mode stays constant at 1.
REQ-032 dout_ready held 0 for 5 cycles in DONE -> dout and dout_valid stable; a din_valid pulse in that window is not accepted (din_ready=0).
REQ-033 Back-to-back 4'b0001 then 4'b1000, dir=0, dout_ready=1 -> the two acceptances are 11 cycles apart, giving dout 4'b0001 then 4'b1000.
REQ-034 rst=0 asserted mid-SHIFT (cnt=6) -> all outputs 0 immediately; no dout_valid after release; the next word 4'b0110 returns 4'b0110.
REQ-035 SHIFT_SEQ_CHK_EN build: force sr4_bidir s_out to 0 during capture with din=4'b1111 -> err=1 in DONE; the normal loopback case gives err=0.
